// File: rtl/fp_mult_pkg.sv
// -----------------------------------------------------------------------------
// fp_mult_pkg
// Shared definitions for the pipelined floating-point multiplier:
//   - rounding-mode encodings (RND_TRUNC / RND_RNE)
//   - helpers deriving word width and exponent bias from the field widths
// Word format: {sign, exponent[EXP_W-1:0], mantissa[MAN_W-1:0]}.
// -----------------------------------------------------------------------------
package fp_mult_pkg;

    typedef enum logic {
        RND_TRUNC = 1'b0,
        RND_RNE   = 1'b1
    } rnd_mode_e;

    // Total word width: sign + exponent + stored mantissa.
    function automatic int unsigned fp_width(input int unsigned exp_w,
                                             input int unsigned man_w);
        return 32'd1 + exp_w + man_w;
    endfunction

    // Exponent bias: 2^(EXP_W-1) - 1.
    function automatic int unsigned fp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/fp_norm_round.sv
// -----------------------------------------------------------------------------
// fp_norm_round
// Combinational final stage of the multiplier: normalises the raw mantissa
// product, rounds (truncate or round-to-nearest-even), range-checks the
// exponent and packs the result word with overflow / underflow flags.
// Ports:
//   sign_i  - result sign
//   zero_i  - one of the operands was zero
//   exp_i   - signed Xe + Ye - BIAS (EXP_W+2 bits)
//   prod_i  - full 2*(MAN_W+1)-bit product of {1,mantissa} operands
//   rnd_i   - rounding mode (RND_TRUNC / RND_RNE)
//   z_o     - packed result
//   ovf_o   - exponent overflow, result saturated
//   unf_o   - exponent underflow, result flushed to zero
// -----------------------------------------------------------------------------
module fp_norm_round
    import fp_mult_pkg::*;
#(
    parameter  int unsigned EXP_W = 4,
    parameter  int unsigned MAN_W = 7,
    localparam int unsigned W     = fp_width(EXP_W, MAN_W),
    localparam int unsigned EW    = EXP_W + 2,
    localparam int unsigned PW    = 2 * (MAN_W + 1)
) (
    input  logic                 sign_i,
    input  logic                 zero_i,
    input  logic signed [EW-1:0] exp_i,
    input  logic        [PW-1:0] prod_i,
    input  logic                 rnd_i,
    output logic        [W-1:0]  z_o,
    output logic                 ovf_o,
    output logic                 unf_o
);

    localparam logic signed [EW-1:0] E_MAX = EW'((32'd1 << EXP_W) - 32'd1);
    localparam logic signed [EW-1:0] E_MIN = EW'(1);

    logic                 norm;
    logic [MAN_W-1:0]     man_t;
    logic                 guard;
    logic                 sticky;
    logic                 inc;
    logic [MAN_W:0]       man_r;
    logic                 carry;
    logic [MAN_W-1:0]     man_out;
    logic signed [EW-1:0] e_fin;

    always_comb begin
        // Product of two values in [1,2) lies in [1,4); the MSB says which.
        norm = prod_i[PW-1];
        if (norm) begin
            man_t  = prod_i[PW-2 -: MAN_W];
            guard  = prod_i[MAN_W];
            sticky = |prod_i[MAN_W-1:0];
        end else begin
            man_t  = prod_i[PW-3 -: MAN_W];
            guard  = prod_i[MAN_W-1];
            sticky = |prod_i[MAN_W-2:0];
        end

        inc     = (rnd_i == RND_RNE) && guard && (sticky || man_t[0]);
        man_r   = {1'b0, man_t} + (MAN_W+1)'(inc);
        carry   = man_r[MAN_W];
        man_out = carry ? '0 : man_r[MAN_W-1:0];
        e_fin   = exp_i + EW'(norm) + EW'(carry);

        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (zero_i) begin
            z_o = {sign_i, {(W-1){1'b0}}};
        end else if (e_fin > E_MAX) begin
            z_o   = {sign_i, {(W-1){1'b1}}};
            ovf_o = 1'b1;
        end else if (e_fin < E_MIN) begin
            z_o   = {sign_i, {(W-1){1'b0}}};
            unf_o = 1'b1;
        end else begin
            z_o = {sign_i, e_fin[EXP_W-1:0], man_out};
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// -----------------------------------------------------------------------------
// fp_mult_pipe
// Three-stage pipelined floating-point multiplier with valid/ready handshake
// on both sides. No subnormals, Inf or NaN: exponent 0 means zero.
//   S1: unpack, sign, biased exponent sum, zero detect
//   S2: full-width mantissa product
//   S3: normalise / round / pack (fp_norm_round), registered on the output
// Ports:
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready - operand handshake; in_ready = !out_valid || out_ready
//   X, Y, rnd_mode    - operands and rounding mode (0 trunc, 1 RNE)
//   out_valid/out_ready - result handshake
//   Z, ovf, unf       - result word and range flags
// -----------------------------------------------------------------------------
module fp_mult_pipe
    import fp_mult_pkg::*;
#(
    parameter  int unsigned EXP_W = 4,
    parameter  int unsigned MAN_W = 7,
    localparam int unsigned W     = fp_width(EXP_W, MAN_W),
    localparam int unsigned BIAS  = fp_bias(EXP_W)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    input  logic         rnd_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Z,
    output logic         ovf,
    output logic         unf
);

    localparam int unsigned EW = EXP_W + 2;
    localparam int unsigned MW = MAN_W + 1;
    localparam int unsigned PW = 2 * MW;

    logic en;

    // S1
    logic                 s1_zero_d;
    logic signed [EW-1:0] s1_exp_d;
    logic                 s1_valid_q;
    logic                 s1_sign_q;
    logic                 s1_zero_q;
    logic signed [EW-1:0] s1_exp_q;
    logic [MW-1:0]        s1_mx_q;
    logic [MW-1:0]        s1_my_q;
    logic                 s1_rnd_q;

    // S2
    logic [PW-1:0]        s2_prod_d;
    logic                 s2_valid_q;
    logic                 s2_sign_q;
    logic                 s2_zero_q;
    logic signed [EW-1:0] s2_exp_q;
    logic [PW-1:0]        s2_prod_q;
    logic                 s2_rnd_q;

    // S3 / output
    logic [W-1:0]         s3_z;
    logic                 s3_ovf;
    logic                 s3_unf;
    logic                 out_valid_q;
    logic [W-1:0]         z_q;
    logic                 ovf_q;
    logic                 unf_q;

    // The whole pipe moves together; a stalled output freezes every stage.
    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    always_comb begin
        s1_zero_d = (X[W-2 -: EXP_W] == '0) || (Y[W-2 -: EXP_W] == '0);
        s1_exp_d  = EW'(X[W-2 -: EXP_W]) + EW'(Y[W-2 -: EXP_W]) - EW'(BIAS);
        s2_prod_d = PW'(s1_mx_q) * PW'(s1_my_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (en) begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                z_q   <= s3_z;
                ovf_q <= s3_ovf;
                unf_q <= s3_unf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (in_valid) begin
                s1_sign_q <= X[W-1] ^ Y[W-1];
                s1_zero_q <= s1_zero_d;
                s1_exp_q  <= s1_exp_d;
                s1_mx_q   <= {1'b1, X[MAN_W-1:0]};
                s1_my_q   <= {1'b1, Y[MAN_W-1:0]};
                s1_rnd_q  <= rnd_mode;
            end
            if (s1_valid_q) begin
                s2_sign_q <= s1_sign_q;
                s2_zero_q <= s1_zero_q;
                s2_exp_q  <= s1_exp_q;
                s2_prod_q <= s2_prod_d;
                s2_rnd_q  <= s1_rnd_q;
            end
        end
    end

    fp_norm_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_norm_round (
        .sign_i (s2_sign_q),
        .zero_i (s2_zero_q),
        .exp_i  (s2_exp_q),
        .prod_i (s2_prod_q),
        .rnd_i  (s2_rnd_q),
        .z_o    (s3_z),
        .ovf_o  (s3_ovf),
        .unf_o  (s3_unf)
    );

    assign out_valid = out_valid_q;
    assign Z         = z_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
module tb_fp_mult_pipe;

    localparam int EXP_W = 4;
    localparam int MAN_W = 7;
    localparam int W     = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         rnd_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Z;
    logic         ovf;
    logic         unf;

    always #5 clk = ~clk;

    fp_mult_pipe #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .rnd_mode  (rnd_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Z         (Z),
        .ovf       (ovf),
        .unf       (unf)
    );

    typedef struct {
        logic [W-1:0] z;
        logic         o;
        logic         u;
        int unsigned  acc;
        bit           lat;
        string        name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    bit          bp_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, need %0h", nm, act, req);
        end
    endtask

    // Independent reference: integer arithmetic on the value, not on bit slices.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic r, output logic [W-1:0] z,
                                  output logic o, output logic u);
        int ex, ey, mx, my, p, e, sh, m, rem, half;
        logic s;
        s  = x[11] ^ y[11];
        ex = int'(x[10:7]);
        ey = int'(y[10:7]);
        o  = 1'b0;
        u  = 1'b0;
        if (ex == 0 || ey == 0) begin
            z = {s, 11'h000};
            return;
        end
        mx = 128 + int'(x[6:0]);
        my = 128 + int'(y[6:0]);
        p  = mx * my;
        e  = ex + ey - 7;
        if (p >= 32768) begin sh = 8; e++; end
        else sh = 7;
        m    = p >> sh;
        rem  = p % (1 << sh);
        half = 1 << (sh - 1);
        if (r && (rem > half || (rem == half && (m % 2) == 1))) m++;
        if (m == 256) begin m = 128; e++; end
        if (e > 15) begin z = {s, 11'h7FF}; o = 1'b1; end
        else if (e < 1) begin z = {s, 11'h000}; u = 1'b1; end
        else z = {s, 4'(e), 7'(m - 128)};
    endfunction

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready_rule", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got Z=%h, need no output", Z);
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_Z"},   {20'd0, Z},   {20'd0, mon_e.z});
                    check({mon_e.name, "_ovf"}, {31'd0, ovf}, {31'd0, mon_e.o});
                    check({mon_e.name, "_unf"}, {31'd0, unf}, {31'd0, mon_e.u});
                    if (mon_e.lat) check({mon_e.name, "_lat"}, cyc - mon_e.acc, 32'd3);
                end
            end
        end
    end

    // Called one time unit after a rising edge; returns likewise after acceptance.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic r,
                        input logic [W-1:0] ez, input logic eo, input logic eu,
                        input string nm, input bit lat);
        exp_t e;
        X        = x;
        Y        = y;
        rnd_mode = r;
        in_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                e.z = ez; e.o = eo; e.u = eu; e.acc = cyc; e.lat = lat; e.name = nm;
                sb.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        total++;
        bad++;
        $display("FAIL %s_accept: got no acceptance in 200 cycles, need acceptance", nm);
        in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic r, input string nm);
        logic [W-1:0] z;
        logic o, u;
        model(x, y, r, z, o, u);
        send(x, y, r, z, o, u, nm, 1'b0);
    endtask

    task automatic drain(input string nm);
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: got %0d results outstanding, need 0", nm, sb.size());
        end
    endtask

    // Random output backpressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_on) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        X         = '0;
        Y         = '0;
        rnd_mode  = 1'b0;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_Z",         {20'd0, Z},         32'd0);
        check("rst_ovf",       {31'd0, ovf},       32'd0);
        check("rst_unf",       {31'd0, unf},       32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors, hand-computed, out_ready held high.
        send(12'h3C0, 12'h3C0, 1'b0, 12'h410, 1'b0, 1'b0, "sq_1p5",     1'b1);
        send(12'hC00, 12'h3C0, 1'b0, 12'hC40, 1'b0, 1'b0, "neg2_x_1p5", 1'b1);
        send(12'h381, 12'h3C0, 1'b0, 12'h3C1, 1'b0, 1'b0, "tie_trunc",  1'b1);
        send(12'h381, 12'h3C0, 1'b1, 12'h3C2, 1'b0, 1'b0, "tie_rne",    1'b1);
        send(12'h3B5, 12'h3B5, 1'b0, 12'h3FF, 1'b0, 1'b0, "carry_trunc", 1'b1);
        send(12'h3B5, 12'h3B5, 1'b1, 12'h400, 1'b0, 1'b0, "carry_rne",  1'b1);
        send(12'h7FF, 12'h7FF, 1'b0, 12'h7FF, 1'b1, 1'b0, "ovf_pos",    1'b1);
        send(12'hFFF, 12'h7FF, 1'b1, 12'hFFF, 1'b1, 1'b0, "ovf_neg",    1'b1);
        send(12'h080, 12'h080, 1'b0, 12'h000, 1'b0, 1'b1, "unf",        1'b1);
        send(12'h800, 12'h380, 1'b0, 12'h800, 1'b0, 1'b0, "neg_zero",   1'b1);
        send(12'h3C0, 12'h000, 1'b1, 12'h000, 1'b0, 1'b0, "pos_zero",   1'b1);
        send(12'h080, 12'h380, 1'b0, 12'h080, 1'b0, 1'b0, "emin_edge",  1'b1);
        send(12'h380, 12'h780, 1'b0, 12'h780, 1'b0, 1'b0, "emax_edge",  1'b1);
        send(12'h400, 12'h780, 1'b0, 12'h7FF, 1'b1, 1'b0, "emax_plus1", 1'b1);
        drain("directed");

        // Random stream under random backpressure, checked in order.
        bp_on = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_model(12'($urandom), 12'($urandom), 1'($urandom_range(0, 1)),
                       $sformatf("rand%0d", i));
        end
        @(posedge clk);
        #1;
        bp_on     = 1'b0;
        out_ready = 1'b1;
        drain("backpressure");

        // Reset with work in flight: one result stalled at the output, one in S2.
        out_ready = 1'b0;
        send(12'h3C0, 12'h3C0, 1'b0, 12'h410, 1'b0, 1'b0, "flightA", 1'b0);
        send(12'hC00, 12'h3C0, 1'b0, 12'hC40, 1'b0, 1'b0, "flightB", 1'b0);
        @(posedge clk);
        #1;
        check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_Z",         {20'd0, Z},         32'd0);
        check("async_rst_in_ready",  {31'd0, in_ready},  32'd1);
        sb.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        send(12'h381, 12'h3C0, 1'b1, 12'h3C2, 1'b0, 1'b0, "after_rst", 1'b1);
        drain("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
